// File: rtl/cons_unit.sv
// -----------------------------------------------------------------------------
// cons_unit
//
// Memory initiator for the Lisp core. Executes CAR, CDR and CONS commands
// against the 16-bit-word cell memory, hiding the cell layout and the
// allocation sequencing from the evaluator FSM.
//
// Cell layout: a cons pointer is {tag[15:12], addr[11:0]}. The CAR word
// lives at addr and the CDR word at addr-1. Allocation writes the CDR first
// and then the CAR, so a contiguous bump allocator yields car_addr = cdr_addr+1.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only when idle)
//   cmd_op                     00 CAR, 01 CDR, 10 CONS, 11 reserved (error)
//   cmd_ptr                    pointer operand for CAR/CDR
//   cmd_car / cmd_cdr          words to allocate for CONS
//   rsp_valid / rsp_ready      response handshake
//   rsp_data / rsp_error       fetched word or new cons pointer, error flag
//   mem_req / mem_addr         one-cycle read request and address
//   mem_data_ready / _out      read data strobe and data
//   mem_write_enable / _data   bump-allocating write strobe and word
//   mem_write_result_addr      address of the last allocated word, valid the
//                              cycle after its write strobe
// -----------------------------------------------------------------------------
module cons_unit #(
    parameter logic [3:0]  ConsTag   = 4'h1,
    parameter logic [15:0] NilWord   = 16'h0000,
    parameter int unsigned HeapLimit = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_ptr,
    input  logic [15:0] cmd_car,
    input  logic [15:0] cmd_cdr,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_error,

    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_data_ready,
    input  logic [15:0] mem_data_out,

    output logic        mem_write_enable,
    output logic [15:0] mem_write_data,
    input  logic [11:0] mem_write_result_addr
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_CDR,
        WR_CAR,
        WR_WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_CAR  = 2'b00,
        OP_CDR  = 2'b01,
        OP_CONS = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    state_t      state_q;
    state_t      state_d;

    op_t         op_q;
    logic [11:0] ptr_q;
    logic [15:0] car_q;
    logic [15:0] cdr_q;
    logic [11:0] cdr_addr_q;
    logic [15:0] rsp_data_q;
    logic        rsp_error_q;

    op_t         cmd_op_t;
    logic        cmd_fire;
    logic        cmd_bad;
    logic        rsp_fire;
    logic        cons_ok;

    assign cmd_op_t = op_t'(cmd_op);
    assign cmd_fire = cmd_valid && (state_q == IDLE);
    assign rsp_fire = rsp_ready && (state_q == RESP);

    // Commands rejected at acceptance never touch memory: reserved op,
    // CAR/CDR of a non-cons pointer, or CDR of address 0 (its CDR word
    // would sit at address -1).
    always_comb begin
        cmd_bad = 1'b0;
        case (cmd_op_t)
            OP_CAR:  cmd_bad = (cmd_ptr[15:12] != ConsTag);
            OP_CDR:  cmd_bad = (cmd_ptr[15:12] != ConsTag) ||
                               (cmd_ptr[11:0] == 12'h000);
            OP_CONS: cmd_bad = 1'b0;
            default: cmd_bad = 1'b1;
        endcase
    end

    // Sampled during WR_WAIT, when the result port reports the CAR address.
    // The +1 comparison is 12 bits wide so allocation may wrap past 0xFFF.
    assign cons_ok = (mem_write_result_addr == cdr_addr_q + 12'd1) &&
                     (32'(mem_write_result_addr) < HeapLimit);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        state_d = RESP;
                    end else if (cmd_op_t == OP_CONS) begin
                        state_d = WR_CDR;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                if (mem_data_ready) begin
                    state_d = RESP;
                end
            end
            WR_CDR:  state_d = WR_CAR;
            WR_CAR:  state_d = WR_WAIT;
            WR_WAIT: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_CAR;
            ptr_q       <= '0;
            car_q       <= '0;
            cdr_q       <= '0;
            cdr_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q        <= cmd_op_t;
                ptr_q       <= cmd_ptr[11:0];
                car_q       <= cmd_car;
                cdr_q       <= cmd_cdr;
                rsp_data_q  <= cmd_bad ? NilWord : '0;
                rsp_error_q <= cmd_bad;
            end

            if (state_q == RD_WAIT && mem_data_ready) begin
                rsp_data_q  <= mem_data_out;
                rsp_error_q <= 1'b0;
            end

            if (state_q == WR_CAR) begin
                cdr_addr_q <= mem_write_result_addr;
            end

            if (state_q == WR_WAIT) begin
                rsp_data_q  <= cons_ok ? {ConsTag, mem_write_result_addr} : NilWord;
                rsp_error_q <= !cons_ok;
            end

            // Clearing on transfer keeps the response outputs at 0 whenever
            // no response is being presented.
            if (rsp_fire) begin
                rsp_data_q  <= '0;
                rsp_error_q <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_data         = rsp_data_q;
        rsp_error        = rsp_error_q;
        mem_req          = 1'b0;
        mem_addr         = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = (op_q == OP_CDR) ? (ptr_q - 12'd1) : ptr_q;
            end
            WR_CDR: begin
                mem_write_enable = 1'b1;
                mem_write_data   = cdr_q;
            end
            WR_CAR: begin
                mem_write_enable = 1'b1;
                mem_write_data   = car_q;
            end
            RESP: rsp_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cons_unit.sv
module tb_cons_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_ptr;
    logic [15:0] cmd_car;
    logic [15:0] cmd_cdr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_error;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_data_ready;
    logic [15:0] mem_data_out;
    logic        mem_write_enable;
    logic [15:0] mem_write_data;
    logic [11:0] mem_write_result_addr;

    int unsigned pass_cnt = 0;
    int unsigned tot_cnt  = 0;

    // memory model controls
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        hp_ld = 1'b0;
    logic [11:0] hp_val = '0;
    logic        ovr_en = 1'b0;
    logic [11:0] ovr_val = '0;

    logic [15:0] mem [4096];
    logic [11:0] heap = '0;
    logic [11:0] res_q = '0;
    logic        prev_we = 1'b0;

    // protocol monitor
    int unsigned viol_cnt = 0;
    int unsigned acc_cnt  = 0;
    int unsigned rsp_cnt  = 0;
    int unsigned we_run   = 0;

    always #5 clk = ~clk;

    cons_unit #(
        .ConsTag   (4'h1),
        .NilWord   (16'h0000),
        .HeapLimit (256)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_op                (cmd_op),
        .cmd_ptr               (cmd_ptr),
        .cmd_car               (cmd_car),
        .cmd_cdr               (cmd_cdr),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_data              (rsp_data),
        .rsp_error             (rsp_error),
        .mem_req               (mem_req),
        .mem_addr              (mem_addr),
        .mem_data_ready        (mem_data_ready),
        .mem_data_out          (mem_data_out),
        .mem_write_enable      (mem_write_enable),
        .mem_write_data        (mem_write_data),
        .mem_write_result_addr (mem_write_result_addr)
    );

    // One-cycle read port and bump allocator. The override replaces the
    // reported address of the second of two back-to-back writes.
    always @(posedge clk) begin
        mem_data_ready <= mem_req;
        mem_data_out   <= mem_req ? mem[mem_addr] : 16'h0000;
        prev_we        <= mem_write_enable;
        if (hp_ld) begin
            heap <= hp_val;
        end else if (mem_write_enable) begin
            mem[heap] <= mem_write_data;
            heap      <= heap + 12'd1;
            res_q     <= (ovr_en && prev_we) ? ovr_val : heap;
        end
        if (ld_en) mem[ld_addr] <= ld_data;
    end
    assign mem_write_result_addr = res_q;

    always @(posedge clk) begin
        if (mem_req && mem_write_enable) viol_cnt <= viol_cnt + 1;
        if (mem_write_enable && we_run >= 2) viol_cnt <= viol_cnt + 1;
        we_run <= mem_write_enable ? we_run + 1 : 0;
        if (mem_req || mem_write_enable) acc_cnt <= acc_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic set_heap(input logic [11:0] v);
        hp_ld = 1'b1; hp_val = v;
        tick();
        hp_ld = 1'b0;
    endtask

    // Drives one command through the acceptance edge; returns in cycle T1.
    task automatic issue(input logic [1:0] op, input logic [15:0] ptr,
                         input logic [15:0] car, input logic [15:0] cdr);
        cmd_valid = 1'b1; cmd_op = op; cmd_ptr = ptr; cmd_car = car; cmd_cdr = cdr;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Completes a presented response; returns in the following cycle.
    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tot_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else pass_cnt++;
        tot_cnt++; if ({rsp_valid, rsp_error, mem_req, mem_write_enable} !== 4'b0000)
            $display("FAIL reset_strobes got %b want 0000", {rsp_valid, rsp_error, mem_req, mem_write_enable}); else pass_cnt++;
        tot_cnt++; if ({rsp_data, mem_addr, mem_write_data} !== 44'h0)
            $display("FAIL reset_buses got %h want 0", {rsp_data, mem_addr, mem_write_data}); else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        load_word(12'h001, 16'hBEEF);
        load_word(12'h002, 16'hDEAD);
        load_word(12'h003, 16'h0001);
        load_word(12'h004, 16'h0002);
        set_heap(12'h005);
    endtask

    task automatic test_car();
        issue(2'b00, 16'h1004, 16'h0, 16'h0);
        tot_cnt++; if ({mem_req, mem_addr, cmd_ready, rsp_valid} !== {1'b1, 12'h004, 2'b00})
            $display("FAIL car_t1 got req=%b addr=%h rdy=%b vld=%b want 1 004 0 0", mem_req, mem_addr, cmd_ready, rsp_valid); else pass_cnt++;
        tick();
        tot_cnt++; if ({mem_req, mem_addr, rsp_valid} !== {1'b0, 12'h000, 1'b0})
            $display("FAIL car_t2 got req=%b addr=%h vld=%b want 0 000 0", mem_req, mem_addr, rsp_valid); else pass_cnt++;
        tick();
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h0002, 1'b0})
            $display("FAIL car_t3 got vld=%b data=%h err=%b want 1 0002 0", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
        tot_cnt++; if ({rsp_valid, cmd_ready, rsp_data} !== {2'b01, 16'h0000})
            $display("FAIL car_done got vld=%b rdy=%b data=%h want 0 1 0000", rsp_valid, cmd_ready, rsp_data); else pass_cnt++;
    endtask

    task automatic test_cdr();
        issue(2'b01, 16'h1004, 16'h0, 16'h0);
        tot_cnt++; if ({mem_req, mem_addr} !== {1'b1, 12'h003})
            $display("FAIL cdr_t1 got req=%b addr=%h want 1 003", mem_req, mem_addr); else pass_cnt++;
        tick(); tick();
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h0001, 1'b0})
            $display("FAIL cdr_t3 got vld=%b data=%h err=%b want 1 0001 0", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
    endtask

    task automatic test_cons();
        issue(2'b10, 16'h0000, 16'h1004, 16'h0000);
        tot_cnt++; if ({mem_write_enable, mem_write_data, mem_req} !== {1'b1, 16'h0000, 1'b0})
            $display("FAIL cons_t1 got we=%b wd=%h req=%b want 1 0000 0", mem_write_enable, mem_write_data, mem_req); else pass_cnt++;
        tick();
        tot_cnt++; if ({mem_write_enable, mem_write_data} !== {1'b1, 16'h1004})
            $display("FAIL cons_t2 got we=%b wd=%h want 1 1004", mem_write_enable, mem_write_data); else pass_cnt++;
        tick();
        tot_cnt++; if ({mem_write_enable, mem_write_data, rsp_valid} !== {1'b0, 16'h0000, 1'b0})
            $display("FAIL cons_t3 got we=%b wd=%h vld=%b want 0 0000 0", mem_write_enable, mem_write_data, rsp_valid); else pass_cnt++;
        tick();
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h1006, 1'b0})
            $display("FAIL cons_t4 got vld=%b data=%h err=%b want 1 1006 0", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
        tot_cnt++; if ({mem[5], mem[6]} !== {16'h0000, 16'h1004})
            $display("FAIL cons_mem got %h %h want 0000 1004", mem[5], mem[6]); else pass_cnt++;
        issue(2'b00, 16'h1006, 16'h0, 16'h0);
        tick(); tick();
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h1004, 1'b0})
            $display("FAIL cons_readback got vld=%b data=%h err=%b want 1 1004 0", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
    endtask

    task automatic test_errors();
        logic [1:0]  ops  [3];
        logic [15:0] ptrs [3];
        int unsigned acc0;
        ops[0] = 2'b00; ptrs[0] = 16'h0001;
        ops[1] = 2'b01; ptrs[1] = 16'h1000;
        ops[2] = 2'b11; ptrs[2] = 16'h1004;
        acc0 = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], ptrs[i], 16'h1234, 16'h5678);
            tot_cnt++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b11, 16'h0000})
                $display("FAIL err_t1[%0d] got vld=%b err=%b data=%h want 1 1 0000", i, rsp_valid, rsp_error, rsp_data); else pass_cnt++;
            tick();
            take_rsp();
        end
        tot_cnt++; if (acc_cnt !== acc0)
            $display("FAIL err_no_mem got %0d accesses want %0d", acc_cnt, acc0); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int unsigned bad;
        issue(2'b00, 16'h1004, 16'h0, 16'h0);
        tick(); tick();
        // a second command waits at the interface the whole time
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_ptr = 16'h1004;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002 || rsp_error !== 1'b0 ||
                cmd_ready !== 1'b0 || mem_req !== 1'b0) bad++;
            if (c == 5) rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        tot_cnt++; if (bad !== 0)
            $display("FAIL bp_hold got %0d bad cycles want 0", bad); else pass_cnt++;
        tot_cnt++; if ({rsp_valid, cmd_ready, mem_req} !== 3'b010)
            $display("FAIL bp_done got vld=%b rdy=%b req=%b want 0 1 0", rsp_valid, cmd_ready, mem_req); else pass_cnt++;
        tick();
        cmd_valid = 1'b0;
        tot_cnt++; if ({mem_req, mem_addr} !== {1'b1, 12'h003})
            $display("FAIL bp_next_cmd got req=%b addr=%h want 1 003", mem_req, mem_addr); else pass_cnt++;
        tick(); tick();
        take_rsp();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        issue(2'b00, 16'h1004, 16'h0, 16'h0);
        tot_cnt++; if (rsp_valid !== 1'b0)
            $display("FAIL b2b_early_ready got vld=%b want 0", rsp_valid); else pass_cnt++;
        tick(); tick();
        tot_cnt++; if ({rsp_valid, rsp_data} !== {1'b1, 16'h0002})
            $display("FAIL b2b_rsp got vld=%b data=%h want 1 0002", rsp_valid, rsp_data); else pass_cnt++;
        tick();
        issue(2'b01, 16'h1002, 16'h0, 16'h0);
        tot_cnt++; if ({mem_req, mem_addr} !== {1'b1, 12'h001})
            $display("FAIL b2b_second got req=%b addr=%h want 1 001", mem_req, mem_addr); else pass_cnt++;
        tick(); tick();
        tot_cnt++; if ({rsp_valid, rsp_data} !== {1'b1, 16'hBEEF})
            $display("FAIL b2b_second_rsp got vld=%b data=%h want 1 beef", rsp_valid, rsp_data); else pass_cnt++;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_cons(input logic [15:0] car, input logic [15:0] cdr);
        issue(2'b10, 16'h0000, car, cdr);
        tick(); tick(); tick();
    endtask

    task automatic test_heap_limits();
        set_heap(12'h0FE);
        do_cons(16'hAAAA, 16'hBBBB);
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h10FF, 1'b0})
            $display("FAIL limit_last_ok got vld=%b data=%h err=%b want 1 10ff 0", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
        set_heap(12'h0FF);
        do_cons(16'hAAAA, 16'hBBBB);
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h0000, 1'b1})
            $display("FAIL limit_over got vld=%b data=%h err=%b want 1 0000 1", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
        set_heap(12'hFFF);
        do_cons(16'hAAAA, 16'hBBBB);
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h1000, 1'b0})
            $display("FAIL limit_wrap got vld=%b data=%h err=%b want 1 1000 0", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
        set_heap(12'h007);
        ovr_en = 1'b1; ovr_val = 12'h0FF;
        do_cons(16'hAAAA, 16'hBBBB);
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h0000, 1'b1})
            $display("FAIL force_0ff got vld=%b data=%h err=%b want 1 0000 1", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
        set_heap(12'h007);
        ovr_val = 12'h009;
        do_cons(16'hAAAA, 16'hBBBB);
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h0000, 1'b1})
            $display("FAIL noncontig got vld=%b data=%h err=%b want 1 0000 1", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
        ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid_cons();
        int unsigned r0;
        set_heap(12'h010);
        issue(2'b10, 16'h0000, 16'h1111, 16'h2222);
        tick();
        tot_cnt++; if (mem_write_enable !== 1'b1)
            $display("FAIL rst_pre_we got %b want 1", mem_write_enable); else pass_cnt++;
        r0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        tot_cnt++; if ({mem_write_enable, cmd_ready, rsp_valid} !== 3'b010)
            $display("FAIL rst_abort got we=%b rdy=%b vld=%b want 0 1 0", mem_write_enable, cmd_ready, rsp_valid); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        tot_cnt++; if (rsp_cnt !== r0 || cmd_ready !== 1'b1)
            $display("FAIL rst_no_rsp got rsp_cycles=%0d rdy=%b want %0d 1", rsp_cnt, cmd_ready, r0); else pass_cnt++;
        issue(2'b00, 16'h1004, 16'h0, 16'h0);
        tick(); tick();
        tot_cnt++; if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 16'h0002, 1'b0})
            $display("FAIL rst_next_car got vld=%b data=%h err=%b want 1 0002 0", rsp_valid, rsp_data, rsp_error); else pass_cnt++;
        take_rsp();
    endtask

    task automatic test_invariants();
        tot_cnt++; if (viol_cnt !== 0)
            $display("FAIL strobe_invariants got %0d violations want 0", viol_cnt); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ptr = '0; cmd_car = '0; cmd_cdr = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_car();
        test_cdr();
        test_cons();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_heap_limits();
        test_reset_mid_cons();
        test_invariants();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
